acc16_seq: RTL and testbench

- Sequential accumulator stage wrapped around the team's combinational 16-bit adder (sum plus sign/carry/zero/overflow flags).
- Accepts a packet of 16-bit operands over a valid/ready handshake and adds each word into a running accumulator.
- On the last word it presents the final sum, last-add flags, sticky flags and word count over an output valid/ready handshake.
- Sits between an operand source (register file or stream) and a result consumer/status register.

---
 rtl/acc16_seq_pkg.sv | 16 +
 rtl/acc16_seq_if.sv | 34 +++
 rtl/acc16_seq_adder.sv | 22 ++
 rtl/acc16_seq.sv | 111 +++++++++++
 tb/tb_acc16_seq.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/acc16_seq_pkg.sv
// Shared types and constants for the acc16_seq accumulator stage.
// Holds the FSM state encoding, datapath width and saturation limits.
package acc16_seq_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc16_seq_if.sv
// Operand-in / result-out handshake bundle for acc16_seq.
// slave is the accumulator's view; master is the source/consumer side.
interface acc16_seq_if
  import acc16_seq_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_sign;
  logic              out_carry;
  logic              out_zero;
  logic              out_overflow;
  logic              out_sticky_carry;
  logic              out_sticky_ovf;
  logic [CNT_W-1:0]  out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sign, out_carry, out_zero,
           out_overflow, out_sticky_carry, out_sticky_ovf, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_sign, out_carry, out_zero,
           out_overflow, out_sticky_carry, out_sticky_ovf, out_count
  );
endinterface

// File: rtl/acc16_seq_adder.sv
// Combinational 16-bit adder core with sign/carry/zero/overflow flags.
module stru_16bitadder
  import acc16_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              sign,
  output logic              carry,
  output logic              zero,
  output logic              overflow
);
  logic [DATA_W:0] s17;

  assign s17      = {1'b0, a} + {1'b0, b};
  assign sum      = s17[DATA_W-1:0];
  assign carry    = s17[DATA_W];
  assign sign     = sum[DATA_W-1];
  assign zero     = (sum == '0);
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign overflow = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
endmodule

// File: rtl/acc16_seq.sv
// Packet accumulator: sums a stream of 16-bit words and presents the total,
// last-add flags, sticky flags and word count over a valid/ready handshake.
module acc16_seq
  import acc16_seq_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  acc16_seq_if.slave bus
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic              sticky_c_q, sticky_o_q;

  logic [DATA_W-1:0] add_sum;
  logic              add_sign, add_carry, add_zero, add_ovf;

  logic [DATA_W-1:0] out_sum_q;
  logic              out_sign_q, out_carry_q, out_zero_q, out_ovf_q;
  logic              out_sc_q, out_so_q;
  logic [CNT_W-1:0]  out_cnt_q;

  logic accept, release_out;

  stru_16bitadder u_add (
    .a        (acc_q),
    .b        (bus.in_data),
    .sum      (add_sum),
    .sign     (add_sign),
    .carry    (add_carry),
    .zero     (add_zero),
    .overflow (add_ovf)
  );

  // A clr cycle always lands in IDLE, so the block looks ready even from HOLD.
  assign bus.in_ready = (state_q != HOLD) || clr;
  assign accept       = bus.in_valid && bus.in_ready && !clr;
  assign release_out  = (state_q == HOLD) && bus.out_ready;
  assign cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    acc_d = add_sum;
    if ((SATURATE != 0) && add_ovf) acc_d = acc_q[DATA_W-1] ? SAT_NEG : SAT_POS;

    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: if (accept) state_d = bus.in_last ? HOLD : ACCUM;
      HOLD:        if (bus.out_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // NOTE: state is updated with non-blocking assignments only; the async reset
  // branch loads every register, including the result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sticky_c_q  <= 1'b0;
      sticky_o_q  <= 1'b0;
      out_sum_q   <= '0;
      out_sign_q  <= 1'b0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_sc_q    <= 1'b0;
      out_so_q    <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr || release_out) begin
        acc_q      <= '0;
        cnt_q      <= '0;
        sticky_c_q <= 1'b0;
        sticky_o_q <= 1'b0;
      end else if (accept) begin
        acc_q      <= acc_d;
        cnt_q      <= cnt_inc;
        sticky_c_q <= sticky_c_q | add_carry;
        sticky_o_q <= sticky_o_q | add_ovf;
        if (bus.in_last) begin
          out_sum_q   <= acc_d;
          out_sign_q  <= add_sign;
          out_carry_q <= add_carry;
          out_zero_q  <= add_zero;
          out_ovf_q   <= add_ovf;
          out_sc_q    <= sticky_c_q | add_carry;
          out_so_q    <= sticky_o_q | add_ovf;
          out_cnt_q   <= cnt_inc;
        end
      end
    end
  end

  assign bus.out_valid        = (state_q == HOLD);
  assign bus.out_sum          = out_sum_q;
  assign bus.out_sign         = out_sign_q;
  assign bus.out_carry        = out_carry_q;
  assign bus.out_zero         = out_zero_q;
  assign bus.out_overflow     = out_ovf_q;
  assign bus.out_sticky_carry = out_sc_q;
  assign bus.out_sticky_ovf   = out_so_q;
  assign bus.out_count        = out_cnt_q;
endmodule

// File: tb/tb_acc16_seq.sv
// Directed bench for acc16_seq: a wrapping and a saturating instance receive
// identical stimulus and are checked against hand-computed results.
module tb_acc16_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;

  acc16_seq_if #(.CNT_W(8)) if0 ();
  acc16_seq_if #(.CNT_W(8)) if1 ();

  acc16_seq #(.CNT_W(8), .SATURATE(0)) dut0 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if0));
  acc16_seq #(.CNT_W(8), .SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic l);
    if0.in_valid = v; if0.in_data = d; if0.in_last = l;
    if1.in_valid = v; if1.in_data = d; if1.in_last = l;
  endtask

  task automatic set_ready(input logic r);
    if0.out_ready = r;
    if1.out_ready = r;
  endtask

  // Offer one word (called #1 after a rising edge), take it on the next edge.
  task automatic send(input string tag, input logic [15:0] d, input logic l);
    drive(1'b1, d, l);
    check({tag, ".in_ready0"}, {31'd0, if0.in_ready}, 32'd1);
    check({tag, ".in_ready1"}, {31'd0, if1.in_ready}, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic expect_result(input string tag, input logic [15:0] s0, input logic [15:0] s1,
                               input logic sg, input logic cy, input logic z, input logic ov,
                               input logic sc, input logic so, input logic [7:0] cnt);
    check({tag, ".valid0"}, {31'd0, if0.out_valid}, 32'd1);
    check({tag, ".valid1"}, {31'd0, if1.out_valid}, 32'd1);
    check({tag, ".sum0"},   {16'd0, if0.out_sum},   {16'd0, s0});
    check({tag, ".sum1"},   {16'd0, if1.out_sum},   {16'd0, s1});
    check({tag, ".flags0"}, {24'd0, if0.out_sign, if0.out_carry, if0.out_zero, if0.out_overflow,
                             if0.out_sticky_carry, if0.out_sticky_ovf, 2'b00},
                            {24'd0, sg, cy, z, ov, sc, so, 2'b00});
    check({tag, ".flags1"}, {24'd0, if1.out_sign, if1.out_carry, if1.out_zero, if1.out_overflow,
                             if1.out_sticky_carry, if1.out_sticky_ovf, 2'b00},
                            {24'd0, sg, cy, z, ov, sc, so, 2'b00});
    check({tag, ".count0"}, {24'd0, if0.out_count}, {24'd0, cnt});
    check({tag, ".count1"}, {24'd0, if1.out_count}, {24'd0, cnt});
  endtask

  task automatic consume(input string tag);
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
    check({tag, ".drop0"},  {31'd0, if0.out_valid}, 32'd0);
    check({tag, ".drop1"},  {31'd0, if1.out_valid}, 32'd0);
    check({tag, ".ready0"}, {31'd0, if0.in_ready},  32'd1);
  endtask

  initial begin
    drive(1'b0, 16'h0000, 1'b0);
    set_ready(1'b0);
    #1;
    check("rst.in_ready", {31'd0, if0.in_ready}, 32'd1);
    check("rst.valid",    {31'd0, if0.out_valid}, 32'd0);
    check("rst.sum",      {16'd0, if0.out_sum}, 32'd0);
    check("rst.count",    {24'd0, if1.out_count}, 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Negative overflow: wraps to 0x0FFF, saturates to 0x8000.
    send("p1w0", 16'h8FFF, 1'b0);
    send("p1w1", 16'h8000, 1'b1);
    expect_result("p1", 16'h0FFF, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd2);
    consume("p1");

    // Zero result with carry, no signed overflow.
    send("p2w0", 16'hFFFE, 1'b0);
    send("p2w1", 16'h0002, 1'b1);
    expect_result("p2", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
    consume("p2");

    // Positive overflow: wraps to 0x9000, saturates to 0x7FFF.
    send("p3w0", 16'h7000, 1'b0);
    send("p3w1", 16'h2000, 1'b1);
    expect_result("p3", 16'h9000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
    consume("p3");

    // Backpressure with a word offered during HOLD that must be ignored.
    send("p4w0", 16'hAAAA, 1'b0);
    send("p4w1", 16'h5555, 1'b1);
    drive(1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      expect_result("p4hold", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);
      check("p4hold.in_ready0", {31'd0, if0.in_ready}, 32'd0);
      check("p4hold.in_ready1", {31'd0, if1.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    drive(1'b0, 16'h0000, 1'b0);
    consume("p4");
    send("p5w0", 16'h0001, 1'b1);
    expect_result("p5", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    consume("p5");

    // Abort mid-packet; the word offered alongside clr must be dropped.
    send("p6w0", 16'h0010, 1'b0);
    send("p6w1", 16'h0020, 1'b0);
    drive(1'b1, 16'h0100, 1'b1);
    clr = 1'b1;
    check("clr.in_ready", {31'd0, if0.in_ready}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    drive(1'b0, 16'h0000, 1'b0);
    check("clr.valid0", {31'd0, if0.out_valid}, 32'd0);
    check("clr.valid1", {31'd0, if1.out_valid}, 32'd0);
    send("p7w0", 16'h0003, 1'b1);
    expect_result("p7", 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    consume("p7");

    // Word counter saturates at 255 over a 301-word packet of zeros.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 16'h0000, 1'b0);
      @(posedge clk); #1;
    end
    send("p8last", 16'h0000, 1'b1);
    expect_result("p8", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
    consume("p8");

    // Asynchronous reset while a result is held.
    send("p9w0", 16'h0005, 1'b1);
    check("p9.valid", {31'd0, if0.out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid0", {31'd0, if0.out_valid}, 32'd0);
    check("arst.valid1", {31'd0, if1.out_valid}, 32'd0);
    check("arst.sum0",   {16'd0, if0.out_sum},   32'd0);
    check("arst.count1", {24'd0, if1.out_count}, 32'd0);
    check("arst.in_ready", {31'd0, if0.in_ready}, 32'd1);
    check("arst.flags1", {26'd0, if1.out_sign, if1.out_carry, if1.out_zero, if1.out_overflow,
                          if1.out_sticky_carry, if1.out_sticky_ovf}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
